// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller.
// State encoding and default operand width live here so that the
// controller and any surrounding logic agree on them.
package serial_adder_pkg;

   // Default operand/result width in bits.
   localparam int DEFAULT_WIDTH = 8;

   // Controller states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_fa_cell.sv
// fa_cell: single-bit full adder for the serial adder datapath.
// Purely combinational. Sum and carry are ORs of decoded minterms of
// the input triple {a, b, c}.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic sum,
   output logic carry
);

   logic m1, m2, m3, m4, m5, m6, m7;

   // Decode the minterms of {a, b, c} and combine them into sum and carry.
   always_comb begin
      m1    = ~a & ~b &  c;
      m2    = ~a &  b & ~c;
      m3    = ~a &  b &  c;
      m4    =  a & ~b & ~c;
      m5    =  a & ~b &  c;
      m6    =  a &  b & ~c;
      m7    =  a &  b &  c;
      sum   = m1 | m2 | m4 | m7;
      carry = m3 | m5 | m6 | m7;
   end

endmodule : fa_cell

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: computes a + b + cin one bit per clock, LSB first,
// through a single fa_cell. IDLE -> RUN (WIDTH cycles) -> DONE.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the registered
// signed-overflow output ovf.
module serial_adder_ctrl #(
   parameter int WIDTH = serial_adder_pkg::DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   import serial_adder_pkg::*;

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic [WIDTH-1:0] res_next;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_s;
   logic             fa_c;

   fa_cell u_fa (
      .a     (a_sr[0]),
      .b     (b_sr[0]),
      .c     (carry),
      .sum   (fa_s),
      .carry (fa_c)
   );

   // Result shift register contents after the current bit is shifted in
   // at the MSB; on the last bit this is the complete result.
   always_comb begin
      res_next = {fa_s, res_sr[WIDTH-1:1]};
   end

   // Controller FSM with operand, carry, result and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         sum    <= '0;
         cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  carry <= cin;
                  cnt   <= '0;
                  state <= RUN;
               end
            end

            RUN: begin
               res_sr <= res_next;
               carry  <= fa_c;
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               if (cnt == LAST) begin
                  // The last bit is still in flight, so sum takes the
                  // post-shift value rather than res_sr itself.
                  sum   <= res_next;
                  cout  <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
                  // carry currently holds the carry into the MSB.
                  ovf   <= carry ^ fa_c;
`endif
                  state <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            DONE: begin
               if (start) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  carry <= cin;
                  cnt   <= '0;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Status outputs decoded from the registered state only.
   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8).
// Checks ovf as well when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic         ovf;
`endif

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         ci;
      logic [W-1:0] s;
      logic         co;
      logic         ov;
   } vec_t;

   typedef struct {
      logic [W-1:0] s;
      logic         co;
      logic         ov;
   } exp_t;

   exp_t         sb[$];
   int           n_cmp = 0;
   int           n_err = 0;
   logic [W-1:0] last_sum  = '0;
   logic         last_cout = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
      vec_t        v;
      logic [W:0]  t;
      t    = {1'b0, ia} + {1'b0, ib} + {{W{1'b0}}, ic};
      v.a  = ia;
      v.b  = ib;
      v.ci = ic;
      v.s  = t[W-1:0];
      v.co = t[W];
      v.ov = (ia[W-1] == ib[W-1]) && (t[W-1] != ia[W-1]);
      return v;
   endfunction

   // Pop the oldest expected result and compare against the DUT outputs.
   task automatic check_result(input string nm);
      exp_t e;
      if (sb.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: done with empty scoreboard, got sum 0x%0h", nm, sum);
      end else begin
         e = sb.pop_front();
         chk({nm, "_sum"}, 32'(sum), 32'(e.s));
         chk({nm, "_cout"}, 32'(cout), 32'(e.co));
`ifdef SERIAL_ADDER_OVF_EN
         chk({nm, "_ovf"}, 32'(ovf), 32'(e.ov));
`endif
         last_sum  = e.s;
         last_cout = e.co;
      end
   endtask

   // One addition from IDLE; optionally pulses start and changes operands mid-RUN.
   task automatic do_add(input string nm, input vec_t v, input bit scramble);
      int cyc;
      int bc;
      cyc = 0;
      bc  = 0;
      sb.push_back('{s: v.s, co: v.co, ov: v.ov});
      a     = v.a;
      b     = v.b;
      cin   = v.ci;
      start = 1'b1;
      tick();
      start = 1'b0;
      while (!done && cyc < 40) begin
         if (busy) bc++;
         if (cyc == 3) begin
            chk({nm, "_sum_held"}, 32'(sum), 32'(last_sum));
            chk({nm, "_cout_held"}, 32'(cout), 32'(last_cout));
         end
         if (scramble && cyc == 2) begin
            start = 1'b1;
            a     = ~v.a;
            b     = 8'h13;
            cin   = ~v.ci;
         end else begin
            start = 1'b0;
         end
         tick();
         cyc++;
      end
      chk({nm, "_latency"}, 32'(cyc), 32'(W));
      chk({nm, "_busy_cycles"}, 32'(bc), 32'(W));
      if (done) check_result(nm);
      else void'(sb.pop_front());
      tick();
      chk({nm, "_done_single"}, 32'(done), 32'd0);
      chk({nm, "_idle_after"}, 32'(busy), 32'd0);
   endtask

   vec_t tbl[7];

   initial begin
      int ndone;
      int prev;
      int badbusy;

      tbl[0] = '{a: 8'h03, b: 8'h05, ci: 1'b0, s: 8'h08, co: 1'b0, ov: 1'b0};
      tbl[1] = '{a: 8'hFF, b: 8'h01, ci: 1'b0, s: 8'h00, co: 1'b1, ov: 1'b0};
      tbl[2] = '{a: 8'h7F, b: 8'h01, ci: 1'b0, s: 8'h80, co: 1'b0, ov: 1'b1};
      tbl[3] = '{a: 8'hAA, b: 8'h55, ci: 1'b1, s: 8'h00, co: 1'b1, ov: 1'b0};
      tbl[4] = '{a: 8'hFF, b: 8'hFF, ci: 1'b1, s: 8'hFF, co: 1'b1, ov: 1'b0};
      tbl[5] = '{a: 8'h80, b: 8'h80, ci: 1'b0, s: 8'h00, co: 1'b1, ov: 1'b1};
      tbl[6] = '{a: 8'h5A, b: 8'h3C, ci: 1'b1, s: 8'h97, co: 1'b0, ov: 1'b1};

      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      cin   = 1'b0;
      tick();
      tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
      chk("rst_ovf", 32'(ovf), 32'd0);
`endif
      rst = 1'b0;
      tick();

      // Table vectors; entry 3 also pulses start and changes operands mid-RUN.
      for (int i = 0; i < 7; i++) begin
         do_add($sformatf("vec%0d", i), tbl[i], (i == 3));
      end

      // Random operands checked against the arithmetic model.
      for (int i = 0; i < 6; i++) begin
         do_add($sformatf("rnd%0d", i),
                model(W'($urandom), W'($urandom), 1'($urandom)), 1'b0);
      end

      // Reset on the 4th RUN cycle aborts the addition.
      a     = 8'h11;
      b     = 8'h22;
      cin   = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      chk("pre_abort_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_sum", 32'(sum), 32'd0);
      chk("abort_cout", 32'(cout), 32'd0);
      tick();
      rst       = 1'b0;
      last_sum  = '0;
      last_cout = 1'b0;
      ndone     = 0;
      badbusy   = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (done) ndone++;
         if (busy) badbusy++;
      end
      chk("abort_no_done", 32'(ndone), 32'd0);
      chk("abort_no_busy", 32'(badbusy), 32'd0);

      // start held high: one result every W+1 cycles.
      a     = 8'h10;
      b     = 8'h20;
      cin   = 1'b0;
      start = 1'b1;
      for (int i = 0; i < 3; i++) sb.push_back('{s: 8'h30, co: 1'b0, ov: 1'b0});
      ndone   = 0;
      prev    = -1;
      badbusy = 0;
      for (int cyc = 0; cyc < 60 && ndone < 3; cyc++) begin
         tick();
         if (busy == done) badbusy++;
         if (done) begin
            check_result($sformatf("b2b%0d", ndone));
            if (prev >= 0) chk("b2b_interval", 32'(cyc - prev), 32'(W + 1));
            prev = cyc;
            ndone++;
            if (ndone == 3) start = 1'b0;
         end
      end
      chk("b2b_count", 32'(ndone), 32'd3);
      chk("b2b_busy_vs_done", 32'(badbusy), 32'd0);
      tick();
      chk("b2b_stop_done", 32'(done), 32'd0);
      chk("b2b_stop_busy", 32'(busy), 32'd0);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1);
   end

endmodule : tb_serial_adder_ctrl
